// File: rtl/rmt_stage_pkg.sv
// Shared stage constants, index type and arbiter state encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rmt_stage_pkg;

  localparam int NUM_SUB_UNIT = 8;
  localparam int PHV_LEN      = 2304;
  localparam int ACT_W        = 4160;
  // One extra bit so that NUM_SUB_UNIT itself can encode "no hit".
  localparam int IDX_W        = $clog2(NUM_SUB_UNIT) + 1;

  typedef logic [IDX_W-1:0] idx_t;

  localparam idx_t MISS_IDX = idx_t'(NUM_SUB_UNIT);

  typedef enum logic {
    COLLECT = 1'b0,
    EMIT    = 1'b1
  } arb_state_e;

endpackage

// File: rtl/sub_match_arbiter_if.sv
// Bundle between the sub-match units, the arbiter and the action engine.
// Latency: n/a (wires only).
// Backpressure: ready_out throttles all sub-units at once; ready_in throttles the beat.
// Ports: phv_in/phv_in_valid, action_in/action_valid_in/action_hit_in, ready_out
//        (sub-unit side); phv_out/action_out/hit_idx_out/out_valid, ready_in (engine side).
// master = stimulus side (sub-units + action engine), slave = the arbiter.
interface sub_match_arbiter_if;
  import rmt_stage_pkg::*;

  logic [PHV_LEN-1:0]            phv_in;
  logic                          phv_in_valid;
  logic [NUM_SUB_UNIT*ACT_W-1:0] action_in;
  logic [NUM_SUB_UNIT-1:0]       action_valid_in;
  logic [NUM_SUB_UNIT-1:0]       action_hit_in;
  logic                          ready_out;
  logic [PHV_LEN-1:0]            phv_out;
  logic [ACT_W-1:0]              action_out;
  idx_t                          hit_idx_out;
  logic                          out_valid;
  logic                          ready_in;

  modport master (
    output phv_in, phv_in_valid, action_in, action_valid_in, action_hit_in, ready_in,
    input  ready_out, phv_out, action_out, hit_idx_out, out_valid
  );

  modport slave (
    input  phv_in, phv_in_valid, action_in, action_valid_in, action_hit_in, ready_in,
    output ready_out, phv_out, action_out, hit_idx_out, out_valid
  );

endinterface

// File: rtl/sub_match_arbiter_lowest_hit_sel.sv
// Priority encoder: lowest set bit of the arriving-and-hit mask.
// Latency: combinational.
// Backpressure: none.
// Ports: req (one bit per sub-unit), idx (lowest set index, N when none), found.
module lowest_hit_sel
  import rmt_stage_pkg::*;
#(
  parameter int N = NUM_SUB_UNIT,
  parameter int W = IDX_W
) (
  input  logic [N-1:0] req,
  output logic [W-1:0] idx,
  output logic         found
);

  // Scan from the top down so the last assignment is the lowest index.
  always_comb begin
    idx   = W'(N);
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sub_match_arbiter.sv
// Collects one result per sub-unit for each PHV, emits the lowest-index hit (or a miss).
// Latency: out_valid one cycle after the last result / PHV arrives (or after the timeout).
// Backpressure: ready_out low while a beat is pending; beat held until ready_in.
// Ports: axis_clk, areset (sync, active high), bus (slave side of the bundle),
//        hit_cnt/miss_cnt (saturating), timeout_err/proto_err (sticky until reset).
module sub_match_arbiter
  import rmt_stage_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 32
) (
  input  logic                axis_clk,
  input  logic                areset,
  sub_match_arbiter_if.slave  bus,
  output logic [CNT_W-1:0]    hit_cnt,
  output logic [CNT_W-1:0]    miss_cnt,
  output logic                timeout_err,
  output logic                proto_err
);

  localparam int TMR_W = $clog2(TIMEOUT + 2);

  arb_state_e              state, state_nxt;
  logic [NUM_SUB_UNIT-1:0] got_mask, got_nxt;
  logic                    phv_got, phv_got_nxt;
  logic [TMR_W-1:0]        timer, timer_nxt;
  idx_t                    sel_idx;
  logic [PHV_LEN-1:0]      phv_q;
  logic [ACT_W-1:0]        act_q;

  logic                    collecting;
  logic [NUM_SUB_UNIT-1:0] arrive, dup_vld, hit_req;
  logic                    phv_take, phv_dup;
  idx_t                    lo_idx;
  logic                    lo_found;
  logic                    take_act;
  logic [ACT_W-1:0]        act_pick;
  logic                    complete, tmo_fire, stray, handshake, active;

  assign collecting = (state == COLLECT);

  // Only first-time results count; repeats are protocol errors and their hits are ignored.
  assign arrive   = collecting ? (bus.action_valid_in & ~got_mask) : '0;
  assign dup_vld  = collecting ? (bus.action_valid_in &  got_mask) : '0;
  assign hit_req  = arrive & bus.action_hit_in;
  assign phv_take = collecting & bus.phv_in_valid & ~phv_got;
  assign phv_dup  = collecting & bus.phv_in_valid &  phv_got;

  lowest_hit_sel #(
    .N (NUM_SUB_UNIT),
    .W (IDX_W)
  ) u_lowest_hit_sel (
    .req   (hit_req),
    .idx   (lo_idx),
    .found (lo_found)
  );

  // A later, lower-index hit replaces an earlier capture.
  assign take_act = lo_found && (lo_idx < sel_idx);

  always_comb begin
    act_pick = '0;
    for (int i = 0; i < NUM_SUB_UNIT; i++) begin
      if (lo_idx == idx_t'(i)) act_pick = bus.action_in[i*ACT_W +: ACT_W];
    end
  end

  always_comb begin
    state_nxt   = state;
    got_nxt     = got_mask;
    phv_got_nxt = phv_got;
    timer_nxt   = timer;
    complete    = 1'b0;
    tmo_fire    = 1'b0;
    stray       = 1'b0;
    handshake   = 1'b0;
    active      = 1'b0;
    case (state)
      COLLECT: begin
        got_nxt     = got_mask | arrive;
        phv_got_nxt = phv_got | phv_take;
        active      = (|got_nxt) | phv_got_nxt;
        complete    = (&got_nxt) & phv_got_nxt;
        // Timer starts on the first cycle anything of this PHV has arrived.
        if (TIMEOUT != 0 && active) timer_nxt = timer + TMR_W'(1);
        tmo_fire = (TIMEOUT != 0) && active && !complete && (timer_nxt >= TMR_W'(TIMEOUT));
        if (complete || tmo_fire) state_nxt = EMIT;
      end
      EMIT: begin
        stray     = (|bus.action_valid_in) | bus.phv_in_valid;
        handshake = bus.ready_in;
        if (handshake) begin
          state_nxt   = COLLECT;
          got_nxt     = '0;
          phv_got_nxt = 1'b0;
          timer_nxt   = '0;
        end
      end
      default: state_nxt = COLLECT;
    endcase
  end

  always_ff @(posedge axis_clk) begin
    if (areset) state <= COLLECT;
    else        state <= state_nxt;
  end

  always_ff @(posedge axis_clk) begin
    if (areset) begin
      got_mask    <= '0;
      phv_got     <= 1'b0;
      timer       <= '0;
      sel_idx     <= MISS_IDX;
      phv_q       <= '0;
      act_q       <= '0;
      hit_cnt     <= '0;
      miss_cnt    <= '0;
      timeout_err <= 1'b0;
      proto_err   <= 1'b0;
    end else begin
      got_mask <= got_nxt;
      phv_got  <= phv_got_nxt;
      timer    <= timer_nxt;
      if (handshake) begin
        // Clearing the data keeps a miss / PHV-less timeout presenting zeros next time.
        sel_idx <= MISS_IDX;
        phv_q   <= '0;
        act_q   <= '0;
        if (sel_idx == MISS_IDX) begin
          if (~&miss_cnt) miss_cnt <= miss_cnt + CNT_W'(1);
        end else begin
          if (~&hit_cnt) hit_cnt <= hit_cnt + CNT_W'(1);
        end
      end else begin
        if (take_act) begin
          sel_idx <= lo_idx;
          act_q   <= act_pick;
        end
        if (phv_take) phv_q <= bus.phv_in;
      end
      if (tmo_fire) timeout_err <= 1'b1;
      if ((|dup_vld) || phv_dup || stray) proto_err <= 1'b1;
    end
  end

  assign bus.ready_out   = collecting & ~areset;
  assign bus.out_valid   = (state == EMIT);
  assign bus.phv_out     = phv_q;
  assign bus.action_out  = act_q;
  assign bus.hit_idx_out = sel_idx;

endmodule

// File: tb/tb_sub_match_arbiter.sv
// Bench for sub_match_arbiter: directed table, corner sequences and random transactions
// against a reference that derives winner and emit cycle from arrival times.
// Two instances: long timeout / wide counters, and short timeout / 2-bit counters.
module tb_sub_match_arbiter;
  import rmt_stage_pkg::*;

  localparam int N = NUM_SUB_UNIT;

  typedef struct packed {
    logic             dsel;
    logic [N-1:0][7:0] arr;     // arrival cycle per unit, 8'hFF = never
    logic [N-1:0]     hits;
    logic [7:0]       phv_at;   // PHV arrival cycle, 8'hFF = never
    logic [7:0]       hold;
    logic             stray;
    logic [7:0]       exp_idx;
    logic [7:0]       exp_emit;
    logic             exp_tmo;
    logic             exp_phv;
  } vec_t;

  logic clk = 1'b0;
  logic areset;
  always #5 clk = ~clk;

  sub_match_arbiter_if if0 ();
  sub_match_arbiter_if if1 ();

  logic [31:0] hc0, mc0;
  logic [1:0]  hc1, mc1;
  logic        te0, pe0, te1, pe1;

  sub_match_arbiter #(.TIMEOUT(64), .CNT_W(32)) u_dut0 (
    .axis_clk (clk), .areset (areset), .bus (if0),
    .hit_cnt (hc0), .miss_cnt (mc0), .timeout_err (te0), .proto_err (pe0)
  );
  sub_match_arbiter #(.TIMEOUT(4), .CNT_W(2)) u_dut1 (
    .axis_clk (clk), .areset (areset), .bus (if1),
    .hit_cnt (hc1), .miss_cnt (mc1), .timeout_err (te1), .proto_err (pe1)
  );

  logic                    sel;
  logic [PHV_LEN-1:0]      d_phv;
  logic                    d_phv_vld;
  logic [N*ACT_W-1:0]      d_act;
  logic [N-1:0]            d_avld, d_ahit;
  logic                    d_rdy;

  assign if0.phv_in          = d_phv;
  assign if1.phv_in          = d_phv;
  assign if0.action_in       = d_act;
  assign if1.action_in       = d_act;
  assign if0.phv_in_valid    = ~sel & d_phv_vld;
  assign if1.phv_in_valid    =  sel & d_phv_vld;
  assign if0.action_valid_in = sel ? '0 : d_avld;
  assign if1.action_valid_in = sel ? d_avld : '0;
  assign if0.action_hit_in   = sel ? '0 : d_ahit;
  assign if1.action_hit_in   = sel ? d_ahit : '0;
  assign if0.ready_in        = ~sel & d_rdy;
  assign if1.ready_in        =  sel & d_rdy;

  logic               o_valid, o_rdy, o_tmo, o_proto;
  idx_t               o_idx;
  logic [ACT_W-1:0]   o_act;
  logic [PHV_LEN-1:0] o_phv;
  logic [31:0]        o_hit, o_miss;

  always_comb begin
    o_valid = sel ? if1.out_valid   : if0.out_valid;
    o_rdy   = sel ? if1.ready_out   : if0.ready_out;
    o_idx   = sel ? if1.hit_idx_out : if0.hit_idx_out;
    o_act   = sel ? if1.action_out  : if0.action_out;
    o_phv   = sel ? if1.phv_out     : if0.phv_out;
    o_hit   = sel ? {30'b0, hc1} : hc0;
    o_miss  = sel ? {30'b0, mc1} : mc0;
    o_tmo   = sel ? te1 : te0;
    o_proto = sel ? pe1 : pe0;
  end

  int     n_chk = 0;
  int     n_fail = 0;
  longint exp_hit[2], exp_miss[2];
  bit     exp_tmo[2], exp_proto[2];
  longint cap[2];

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, a, e);
    end
  endtask

  task automatic chk_w(input string nm, input logic [ACT_W-1:0] a, input logic [ACT_W-1:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got low word %h, expected low word %h", nm, a[63:0], e[63:0]);
    end
  endtask

  function automatic logic [ACT_W-1:0] gen_act(input logic [31:0] seed, input int i);
    logic [ACT_W-1:0] v;
    v = '0;
    for (int w = 0; w < ACT_W / 32; w++)
      v[w*32 +: 32] = (seed * 32'h9E3779B1) ^ (32'(i) * 32'h01000193) ^ 32'(w) ^ 32'h1;
    return v;
  endfunction

  function automatic logic [PHV_LEN-1:0] gen_phv(input logic [31:0] seed);
    logic [PHV_LEN-1:0] v;
    v = '0;
    for (int w = 0; w < PHV_LEN / 32; w++)
      v[w*32 +: 32] = (seed * 32'h85EBCA6B) ^ 32'(w) ^ 32'hC2B2AE35;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    d_phv_vld = 1'b0;
    d_avld    = '0;
    d_ahit    = '0;
    d_rdy     = 1'b0;
  endtask

  // Reference: the beat closes when everything has arrived, or TIMEOUT cycles after the
  // first arrival, whichever is earlier; the winner is the lowest-index hit seen by then.
  task automatic model(input logic [N-1:0][7:0] arr, input logic [N-1:0] hits,
                       input logic [7:0] phv_at, input int tmo,
                       output int idx, output int emit, output bit timed, output bit phv_ok);
    int first, last, endc;
    bit never;
    first = 1000; last = -1; never = 0;
    for (int i = 0; i < N; i++) begin
      if (arr[i] == 8'hFF) never = 1;
      else begin
        if (int'(arr[i]) < first) first = int'(arr[i]);
        if (int'(arr[i]) > last)  last  = int'(arr[i]);
      end
    end
    if (phv_at == 8'hFF) never = 1;
    else begin
      if (int'(phv_at) < first) first = int'(phv_at);
      if (int'(phv_at) > last)  last  = int'(phv_at);
    end
    if (never) last = 1000;
    endc = last;
    timed = 0;
    if (tmo != 0 && last > first + tmo - 1) begin
      endc  = first + tmo - 1;
      timed = 1;
    end
    idx = N;
    for (int i = N - 1; i >= 0; i--)
      if (arr[i] != 8'hFF && int'(arr[i]) <= endc && hits[i]) idx = i;
    emit   = endc + 1;
    phv_ok = (phv_at != 8'hFF) && (int'(phv_at) <= endc);
  endtask

  task automatic drive_cycle(input logic [N-1:0][7:0] arr, input logic [N-1:0] hits,
                             input logic [7:0] phv_at, input int t, input logic [31:0] seed);
    for (int i = 0; i < N; i++) begin
      d_avld[i] = (int'(arr[i]) == t);
      d_act[i*ACT_W +: ACT_W] = d_avld[i] ? gen_act(seed, i) : gen_act(seed ^ 32'h5A5A5A5A, i + 16);
    end
    d_ahit    = d_avld & hits;
    d_phv_vld = (int'(phv_at) == t);
    d_phv     = d_phv_vld ? gen_phv(seed) : gen_phv(~seed);
  endtask

  task automatic chk_beat(input int e_idx, input logic [ACT_W-1:0] e_act,
                          input logic [PHV_LEN-1:0] e_phv);
    chk("out_valid", 64'(o_valid), 64'd1);
    chk("hit_idx", 64'(o_idx), 64'(e_idx));
    chk_w("action_out", o_act, e_act);
    chk_w("phv_out", ACT_W'(o_phv), ACT_W'(e_phv));
  endtask

  task automatic emit_phase(input logic d, input bit seen, input int t, input int e_emit,
                            input int hold, input bit stray, input int e_idx,
                            input logic [ACT_W-1:0] e_act, input logic [PHV_LEN-1:0] e_phv,
                            input bit e_tmo);
    chk("beat_seen", 64'(seen), 64'd1);
    if (!seen) return;
    chk("emit_cycle", 64'(t), 64'(e_emit));
    if (e_tmo) exp_tmo[d] = 1;
    chk("timeout_err", 64'(o_tmo), 64'(exp_tmo[d]));
    for (int h = 0; h < hold; h++) begin
      chk_beat(e_idx, e_act, e_phv);
      chk("ready_out_emit", 64'(o_rdy), 64'd0);
      if (stray && h == 2) d_avld[0] = 1'b1;
      step();
      d_avld = '0;
      if (stray && h == 2) exp_proto[d] = 1;
    end
    chk_beat(e_idx, e_act, e_phv);
    d_rdy = 1'b1;
    step();
    d_rdy = 1'b0;
    if (e_idx == N) begin
      if (exp_miss[d] < cap[d]) exp_miss[d]++;
    end else begin
      if (exp_hit[d] < cap[d]) exp_hit[d]++;
    end
    chk("out_valid_after", 64'(o_valid), 64'd0);
    chk("ready_out_after", 64'(o_rdy), 64'd1);
    chk("hit_cnt", 64'(o_hit), 64'(exp_hit[d]));
    chk("miss_cnt", 64'(o_miss), 64'(exp_miss[d]));
    chk("proto_err", 64'(o_proto), 64'(exp_proto[d]));
  endtask

  task automatic run_txn(input logic d, input logic [N-1:0][7:0] arr, input logic [N-1:0] hits,
                         input logic [7:0] phv_at, input int hold, input bit stray,
                         input int e_idx, input int e_emit, input bit e_tmo, input bit e_phv,
                         input logic [31:0] seed);
    int t;
    bit seen;
    sel  = d;
    t    = 0;
    seen = 0;
    while (!seen && t < 150) begin
      if (o_valid === 1'b1) seen = 1;
      else begin
        drive_cycle(arr, hits, phv_at, t, seed);
        step();
        t++;
      end
    end
    clear_inputs();
    emit_phase(d, seen, t, e_emit, hold, stray, e_idx,
               (e_idx == N) ? '0 : gen_act(seed, e_idx),
               e_phv ? gen_phv(seed) : '0, e_tmo);
  endtask

  task automatic reset_model();
    for (int k = 0; k < 2; k++) begin
      exp_hit[k] = 0; exp_miss[k] = 0; exp_tmo[k] = 0; exp_proto[k] = 0;
    end
  endtask

  vec_t vecs[7];

  initial begin
    #500000;
    $display("FAIL global_time_limit: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    int r_idx, r_emit;
    bit r_tmo, r_phv;
    logic [N-1:0][7:0] r_arr;
    logic [7:0] r_phv_at;
    logic d;

    cap[0] = 64'hFFFF_FFFF;
    cap[1] = 3;
    reset_model();
    sel = 1'b0;
    d_act = '0;
    d_phv = '0;
    clear_inputs();

    //            dsel  arr (unit7 .. unit0)                                hits        phv    hold  stray idx emit tmo phv
    vecs[0] = '{1'b0, {8'd0,8'd0,8'd0,8'd0,8'd0,8'd0,8'd0,8'd0},        8'b0010_1000, 8'd0,  8'd0,  1'b0, 8'd3, 8'd1, 1'b0, 1'b1};
    vecs[1] = '{1'b0, {8'd0,8'd0,8'd0,8'd0,8'd0,8'd4,8'd0,8'd0},        8'b0100_0100, 8'd0,  8'd0,  1'b0, 8'd2, 8'd5, 1'b0, 1'b1};
    vecs[2] = '{1'b0, {8'd0,8'd0,8'd0,8'd0,8'd0,8'd0,8'd0,8'd0},        8'b0000_0000, 8'd0,  8'd1,  1'b0, 8'd8, 8'd1, 1'b0, 1'b1};
    vecs[3] = '{1'b0, {8'd0,8'd0,8'd0,8'd0,8'd0,8'd0,8'd0,8'd0},        8'b1000_0000, 8'd0,  8'd10, 1'b1, 8'd7, 8'd1, 1'b0, 1'b1};
    vecs[4] = '{1'b1, {8'd3,8'd0,8'd0,8'd0,8'd0,8'd0,8'd0,8'd0},        8'b1000_0000, 8'd0,  8'd0,  1'b0, 8'd7, 8'd4, 1'b0, 1'b1};
    vecs[5] = '{1'b1, {8'hFF,8'd3,8'd0,8'd1,8'd2,8'd0,8'd1,8'd0},       8'b0101_0000, 8'd0,  8'd0,  1'b0, 8'd4, 8'd4, 1'b1, 1'b1};
    vecs[6] = '{1'b1, {8'hFF,8'd0,8'd0,8'd0,8'd0,8'd0,8'd0,8'd0},       8'b0000_0000, 8'hFF, 8'd0,  1'b0, 8'd8, 8'd4, 1'b1, 1'b0};

    // Reset state.
    areset = 1'b1;
    step();
    step();
    chk("rst_ready_out", 64'(o_rdy), 64'd0);
    chk("rst_out_valid", 64'(o_valid), 64'd0);
    chk("rst_hit_idx", 64'(o_idx), 64'(N));
    chk_w("rst_action_out", o_act, '0);
    chk("rst_hit_cnt", 64'(o_hit), 64'd0);
    chk("rst_flags", 64'({o_tmo, o_proto}), 64'd0);
    areset = 1'b0;
    #1;
    chk("post_rst_ready_out", 64'(o_rdy), 64'd1);

    // Directed table.
    for (int k = 0; k < 7; k++) begin
      run_txn(vecs[k].dsel, vecs[k].arr, vecs[k].hits, vecs[k].phv_at, int'(vecs[k].hold),
              vecs[k].stray, int'(vecs[k].exp_idx), int'(vecs[k].exp_emit),
              vecs[k].exp_tmo, vecs[k].exp_phv, 32'(k + 1));
    end

    // Reset while a beat is pending, then a fresh collection.
    sel = 1'b0;
    drive_cycle('0, 8'b0000_0010, 8'd0, 0, 32'd77);
    step();
    clear_inputs();
    chk("pre_rst_out_valid", 64'(o_valid), 64'd1);
    areset = 1'b1;
    step();
    areset = 1'b0;
    reset_model();
    chk("mid_rst_out_valid", 64'(o_valid), 64'd0);
    chk("mid_rst_hit_cnt", 64'(o_hit), 64'd0);
    chk("mid_rst_miss_cnt", 64'(o_miss), 64'd0);
    chk("mid_rst_flags", 64'({o_tmo, o_proto}), 64'd0);
    chk("mid_rst_hit_idx", 64'(o_idx), 64'(N));
    chk_w("mid_rst_phv_out", ACT_W'(o_phv), '0);
    #1;
    chk("mid_rst_ready_out", 64'(o_rdy), 64'd1);
    run_txn(1'b0, '0, 8'b0000_0010, 8'd0, 0, 1'b0, 1, 1, 1'b0, 1'b1, 32'd78);

    // Duplicate unit-0 result (now a hit) and duplicate PHV: both ignored, proto_err set.
    sel = 1'b0;
    for (int i = 0; i < N; i++) d_act[i*ACT_W +: ACT_W] = gen_act(32'd90, i);
    d_avld = 8'h7F; d_ahit = '0; d_phv_vld = 1'b1; d_phv = gen_phv(32'd90);
    step();
    d_avld = 8'h81; d_ahit = 8'h01; d_phv_vld = 1'b1; d_phv = gen_phv(32'd91);
    step();
    clear_inputs();
    exp_proto[0] = 1;
    emit_phase(1'b0, o_valid === 1'b1, 2, 2, 0, 1'b0, N, '0, gen_phv(32'd90), 1'b0);

    // Random transactions on both instances.
    for (int k = 0; k < 40; k++) begin
      d = 1'($urandom_range(0, 1));
      for (int i = 0; i < N; i++) begin
        r_arr[i] = 8'($urandom_range(0, 5));
        if (d && i != 0 && $urandom_range(0, 7) == 0) r_arr[i] = 8'hFF;
      end
      r_phv_at = (d && $urandom_range(0, 5) == 0) ? 8'hFF : 8'($urandom_range(0, 5));
      begin
        logic [N-1:0] r_hits;
        r_hits = N'($urandom);
        model(r_arr, r_hits, r_phv_at, d ? 4 : 64, r_idx, r_emit, r_tmo, r_phv);
        run_txn(d, r_arr, r_hits, r_phv_at, int'($urandom_range(0, 2)), 1'b0,
                r_idx, r_emit, r_tmo, r_phv, 32'(1000 + k));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sub_match_arbiter.md
Name: sub_match_arbiter

Overview:
- Sits between the NUM_SUB_UNIT parallel sub-match units of one stage and the action engine.
- Gathers one lookup result from every sub-unit for each PHV and selects the hit from the lowest-indexed sub-unit (miss: all-zero action).
- Presents one PHV+action beat to the action engine with valid/ready, and back-pressures all sub-units through a shared ready.
- Provides hit/miss counters, a collection timeout and sticky protocol-error flags for the control path.

Parameters:
- NUM_SUB_UNIT, 8, number of sub-match units arbitrated
- PHV_LEN, 2304, PHV width in bits
- ACT_W, 4160, per-unit action width (64 bits x 65 containers)
- TIMEOUT, 64, max cycles from first result to forced completion; 0 disables
- CNT_W, 32, counter width

Ports:
- axis_clk  in  1  clock
- areset  in  1  synchronous active-high reset
- phv_in  in  PHV_LEN  PHV accompanying sub-unit 0 result
- phv_in_valid  in  1  phv_in qualifier
- action_in  in  NUM_SUB_UNIT*ACT_W  unit i action at [i*ACT_W +: ACT_W]
- action_valid_in  in  NUM_SUB_UNIT  per-unit result valid (one pulse per PHV)
- action_hit_in  in  NUM_SUB_UNIT  per-unit match hit, qualified by action_valid_in
- ready_out  out  1  shared ready to all sub-units
- phv_out  out  PHV_LEN  selected PHV
- action_out  out  ACT_W  selected action
- hit_idx_out  out  $clog2(NUM_SUB_UNIT)+1  winning unit index; NUM_SUB_UNIT = miss
- out_valid  out  1  beat valid to action engine
- ready_in  in  1  action engine ready
- hit_cnt  out  CNT_W  saturating count of emitted hits
- miss_cnt  out  CNT_W  saturating count of emitted misses
- timeout_err  out  1  sticky: a collection timed out
- proto_err  out  1  sticky: duplicate or out-of-phase valid

Behaviour:
- Reset (areset=1 at a clock edge): state COLLECT; ready_out=0 during the reset cycle and 1 afterwards. out_valid=0, phv_out=0, action_out=0, hit_idx_out=NUM_SUB_UNIT, counters=0, sticky flags=0, got_mask=0, sel_idx=NUM_SUB_UNIT, phv_got=0, timer=0.
- Reset mid-operation discards any partial collection and any pending output beat.
- State COLLECT (ready_out=1):
  - got_mask |= action_valid_in.
  - If phv_in_valid, latch phv_in and set phv_got. A second phv_in_valid in the same collection sets proto_err and is ignored.
  - For each arriving unit i with hit=1 and i < sel_idx: latch action_in slice i and set sel_idx=i. When several hits arrive in one cycle, the lowest index wins. A lower-index hit arriving later replaces an earlier higher-index capture.
  - A valid from a unit already in got_mask sets proto_err and is ignored; its hit is not considered.
  - timer counts from the first cycle got_mask or phv_got becomes non-zero.
- Completion: when got_mask is all-ones (including bits set this cycle) and phv_got (including this cycle), move to EMIT. out_valid=1 on the next cycle, so latency is 1 cycle from the last arrival.
  - Miss: sel_idx=NUM_SUB_UNIT; action_out=0; hit_idx_out=NUM_SUB_UNIT.
- Timeout: if TIMEOUT!=0 and timer reaches TIMEOUT before completion, set timeout_err and move to EMIT with the current selection.
  - If phv_got=0, phv_out=0.
- State EMIT (ready_out=0):
  - out_valid, phv_out, action_out and hit_idx_out are held stable until ready_in=1.
  - On handshake (out_valid & ready_in), return to COLLECT the same edge: got_mask, sel_idx, phv_got and timer are cleared; out_valid=0 next cycle.
  - Increment hit_cnt or miss_cnt at the handshake, saturating at all-ones.
  - action_valid_in or phv_in_valid asserted while in EMIT sets proto_err; the inputs are dropped.
- Throughput: at most one PHV per 2 cycles (collect + emit handshake). A bubble-free pipeline is not required.
- Sticky flags clear only on reset.

Decomposition:
- Shared package `rmt_stage_pkg`:
  - Constants PHV_LEN, ACT_W and NUM_SUB_UNIT.
  - Derived IDX_W = $clog2(NUM_SUB_UNIT)+1.
  - State enum {COLLECT, EMIT}.
- One natural sub-module: `lowest_hit_sel` (combinational priority encoder). It takes the arriving-and-hit mask and returns the lowest index and a found flag. This keeps the per-cycle min-index compare out of the FSM.

Test Plan:
- All 8 units valid in one cycle, hits on units 3 and 5, ready_in=1 → out_valid 1 cycle later, hit_idx_out=3, action_out equals unit 3 slice, hit_cnt=1.
- Units arrive staggered: unit 6 hit at cycle 0, units 0-5 and 7 miss, unit 2 hit at cycle 4 → hit_idx_out=2, out_valid asserted at cycle 5.
- All units miss → action_out=0, hit_idx_out=8, miss_cnt=1, hit_cnt=0.
- ready_in held 0 for 10 cycles after completion → outputs stable, ready_out=0; a stray action_valid_in[0] sets proto_err. Raising ready_in completes one beat; ready_out=1 on the following cycle.
- TIMEOUT=4, only units 0-6 respond → timeout_err=1 after 4 cycles and a beat is emitted with the best hit among 0-6.
- Assert areset during EMIT with out_valid=1 → next cycle out_valid=0, counters=0, flags=0; a fresh full collection then completes normally.
